// File: rtl/vga_pattern_pkg.sv
// Shared constants for the VGA test-pattern generator: mode encodings,
// the 3-bit on/off colour-bar palette and the datapath latency.
package vga_pattern_pkg;

   localparam logic [1:0] MODE_BARS   = 2'd0;
   localparam logic [1:0] MODE_CHECK  = 2'd1;
   localparam logic [1:0] MODE_GRAD   = 2'd2;
   localparam logic [1:0] MODE_SCROLL = 2'd3;

   localparam int unsigned PIPE_LATENCY = 2;

   // Bar colours as {R,G,B} on/off bits; each bit is replicated to COLOR_W in the datapath
   localparam logic [2:0] BAR_WHITE   = 3'b111;
   localparam logic [2:0] BAR_YELLOW  = 3'b110;
   localparam logic [2:0] BAR_CYAN    = 3'b011;
   localparam logic [2:0] BAR_GREEN   = 3'b010;
   localparam logic [2:0] BAR_MAGENTA = 3'b101;
   localparam logic [2:0] BAR_RED     = 3'b100;
   localparam logic [2:0] BAR_BLUE    = 3'b001;
   localparam logic [2:0] BAR_BLACK   = 3'b000;

   function automatic logic [2:0] bar_colour(input logic [2:0] idx);
      logic [2:0] c;
      case (idx)
         3'd0:    c = BAR_WHITE;
         3'd1:    c = BAR_YELLOW;
         3'd2:    c = BAR_CYAN;
         3'd3:    c = BAR_GREEN;
         3'd4:    c = BAR_MAGENTA;
         3'd5:    c = BAR_RED;
         3'd6:    c = BAR_BLUE;
         default: c = BAR_BLACK;
      endcase
      return c;
   endfunction

   function automatic logic [1:0] next_mode(input logic [1:0] m);
      return m + 2'd1;
   endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Timing bundle from the sync generator plus the mode request/report,
// shared between the datapath top and the mode controller.
interface vga_pattern_gen_if;
   logic [11:0] h_count;
   logic [11:0] v_count;
   logic        display_en;
   logic        h_sync;
   logic        v_sync;
   logic        mode_next;
   logic [1:0]  mode;

   modport master (
      output h_count, v_count, display_en, h_sync, v_sync, mode_next,
      input  mode
   );

   modport slave (
      input  h_count, v_count, display_en, h_sync, v_sync, mode_next,
      output mode
   );
endinterface

// File: rtl/vga_pattern_mode_ctrl.sv
// Frame-end detect, request latch, pattern-mode FSM and scroll position.
// Optional `AUTO_CYCLE_EN adds a frame counter that advances the mode every AUTO_FRAMES frames.
module vga_pattern_mode_ctrl
   import vga_pattern_pkg::*;
#(
   parameter int unsigned H_DISPLAY   = 1280,
   parameter int unsigned V_DISPLAY   = 960,
   parameter int unsigned SCROLL_STEP = 4,
   parameter int unsigned AUTO_FRAMES = 120
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   vga_pattern_gen_if.slave      tim,
   output logic [11:0]           scroll_x_o
);

   localparam logic [11:0] V_END  = 12'(V_DISPLAY);
   localparam logic [12:0] H_WRAP = 13'(H_DISPLAY);
   localparam logic [12:0] STEP   = 13'(SCROLL_STEP);

   logic        frame_end;
   logic        auto_hit;
   logic        advance;
   logic [1:0]  mode_q, mode_d;
   logic        pending_q, pending_d;
   logic [11:0] scroll_q, scroll_d;
   logic [12:0] scroll_sum;

   assign frame_end = (tim.v_count == V_END) && (tim.h_count == '0);

`ifdef AUTO_CYCLE_EN
   localparam int unsigned FC_W = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
   logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;

   assign auto_hit = (frame_cnt_q == FC_W'(AUTO_FRAMES - 1));

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      if (frame_end) frame_cnt_d = auto_hit ? '0 : frame_cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) frame_cnt_q <= '0;
      else       frame_cnt_q <= frame_cnt_d;
   end
`else
   assign auto_hit = 1'b0;
`endif

   // Requests and the auto tick merge into one advance per frame-end
   assign advance = frame_end && (pending_q || tim.mode_next || auto_hit);

   assign scroll_sum = {1'b0, scroll_q} + STEP;

   always_comb begin
      mode_d    = advance ? next_mode(mode_q) : mode_q;
      pending_d = frame_end ? 1'b0 : (pending_q | tim.mode_next);
      scroll_d  = scroll_q;
      if (frame_end)
         scroll_d = (scroll_sum >= H_WRAP) ? 12'(scroll_sum - H_WRAP) : scroll_sum[11:0];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mode_q    <= MODE_BARS;
         pending_q <= 1'b0;
         scroll_q  <= '0;
      end else begin
         mode_q    <= mode_d;
         pending_q <= pending_d;
         scroll_q  <= scroll_d;
      end
   end

   assign tim.mode   = mode_q;
   assign scroll_x_o = scroll_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// Two-stage RGB test-pattern datapath (bars, checker, gradient, scrolling bar)
// with syncs/enable re-timed to match. `AUTO_CYCLE_EN enables auto mode cycling.
module vga_pattern_gen
   import vga_pattern_pkg::*;
#(
   parameter int unsigned H_DISPLAY   = 1280,
   parameter int unsigned V_DISPLAY   = 960,
   parameter int unsigned COLOR_W     = 4,
   parameter int unsigned CHECK_SHIFT = 5,
   parameter int unsigned GRAD_SHIFT  = 6,
   parameter int unsigned BAR_W       = 32,
   parameter int unsigned SCROLL_STEP = 4,
   parameter int unsigned AUTO_FRAMES = 120
) (
   input  logic               clk_in,
   input  logic               reset,
   input  logic [11:0]        h_count,
   input  logic [11:0]        v_count,
   input  logic               display_en,
   input  logic               h_sync,
   input  logic               v_sync,
   input  logic               mode_next,
   output logic [COLOR_W-1:0] red,
   output logic [COLOR_W-1:0] green,
   output logic [COLOR_W-1:0] blue,
   output logic               h_sync_out,
   output logic               v_sync_out,
   output logic               display_en_out,
   output logic [1:0]         mode
);

   localparam int unsigned BAR_PX = H_DISPLAY / 8;

   vga_pattern_gen_if tim ();

   assign tim.h_count    = h_count;
   assign tim.v_count    = v_count;
   assign tim.display_en = display_en;
   assign tim.h_sync     = h_sync;
   assign tim.v_sync     = v_sync;
   assign tim.mode_next  = mode_next;
   assign mode           = tim.mode;

   logic [11:0] scroll_x;

   vga_pattern_mode_ctrl #(
      .H_DISPLAY   (H_DISPLAY),
      .V_DISPLAY   (V_DISPLAY),
      .SCROLL_STEP (SCROLL_STEP),
      .AUTO_FRAMES (AUTO_FRAMES)
   ) u_mode_ctrl (
      .clk_i      (clk_in),
      .rst_i      (reset),
      .tim        (tim),
      .scroll_x_o (scroll_x)
   );

   // Stage 1: pattern intermediates from the raw counts
   logic [2:0]         bar_idx;
   logic [2:0]         bar_rgb_d;
   logic               check_d;
   logic [COLOR_W-1:0] grad_r_d, grad_g_d;
   logic [12:0]        scroll_end;
   logic               scroll_d;

   // Bar index is the number of bar boundaries already passed
   always_comb begin
      bar_idx = '0;
      for (int unsigned k = 1; k < 8; k++)
         if (tim.h_count >= 12'(k * BAR_PX)) bar_idx = 3'(k);
   end

   assign bar_rgb_d  = bar_colour(bar_idx);
   assign check_d    = tim.h_count[CHECK_SHIFT] ^ tim.v_count[CHECK_SHIFT];
   assign grad_r_d   = tim.h_count[GRAD_SHIFT +: COLOR_W];
   assign grad_g_d   = tim.v_count[GRAD_SHIFT +: COLOR_W];
   assign scroll_end = {1'b0, scroll_x} + 13'(BAR_W);
   assign scroll_d   = (tim.h_count >= scroll_x) && ({1'b0, tim.h_count} < scroll_end);

   logic               de1_q, hs1_q, vs1_q;
   logic [1:0]         mode1_q;
   logic [2:0]         bar_rgb1_q;
   logic               check1_q;
   logic [COLOR_W-1:0] grad_r1_q, grad_g1_q;
   logic               scroll1_q;

   always_ff @(posedge clk_in) begin
      if (reset) begin
         de1_q      <= 1'b0;
         hs1_q      <= 1'b1;
         vs1_q      <= 1'b1;
         mode1_q    <= MODE_BARS;
         bar_rgb1_q <= '0;
         check1_q   <= 1'b0;
         grad_r1_q  <= '0;
         grad_g1_q  <= '0;
         scroll1_q  <= 1'b0;
      end else begin
         de1_q      <= tim.display_en;
         hs1_q      <= tim.h_sync;
         vs1_q      <= tim.v_sync;
         mode1_q    <= tim.mode;
         bar_rgb1_q <= bar_rgb_d;
         check1_q   <= check_d;
         grad_r1_q  <= grad_r_d;
         grad_g1_q  <= grad_g_d;
         scroll1_q  <= scroll_d;
      end
   end

   // Stage 2: mode select, blanking and output registers
   logic [COLOR_W-1:0] red_d, green_d, blue_d;
   logic [COLOR_W-1:0] red_q, green_q, blue_q;
   logic               hs2_q, vs2_q, de2_q;

   always_comb begin
      red_d   = '0;
      green_d = '0;
      blue_d  = '0;
      case (mode1_q)
         MODE_BARS: begin
            red_d   = {COLOR_W{bar_rgb1_q[2]}};
            green_d = {COLOR_W{bar_rgb1_q[1]}};
            blue_d  = {COLOR_W{bar_rgb1_q[0]}};
         end
         MODE_CHECK: begin
            red_d   = check1_q ? '0 : '1;
            green_d = check1_q ? '0 : '1;
            blue_d  = check1_q ? '0 : '1;
         end
         MODE_GRAD: begin
            red_d   = grad_r1_q;
            green_d = grad_g1_q;
            blue_d  = grad_r1_q ^ grad_g1_q;
         end
         default: begin
            red_d   = scroll1_q ? '1 : '0;
            green_d = scroll1_q ? '1 : '0;
            blue_d  = scroll1_q ? '1 : '0;
         end
      endcase
      if (!de1_q) begin
         red_d   = '0;
         green_d = '0;
         blue_d  = '0;
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         red_q   <= '0;
         green_q <= '0;
         blue_q  <= '0;
         hs2_q   <= 1'b1;
         vs2_q   <= 1'b1;
         de2_q   <= 1'b0;
      end else begin
         red_q   <= red_d;
         green_q <= green_d;
         blue_q  <= blue_d;
         hs2_q   <= hs1_q;
         vs2_q   <= vs1_q;
         de2_q   <= de1_q;
      end
   end

   assign red            = red_q;
   assign green          = green_q;
   assign blue           = blue_q;
   assign h_sync_out     = hs2_q;
   assign v_sync_out     = vs2_q;
   assign display_en_out = de2_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen; honours `AUTO_CYCLE_EN with AUTO_FRAMES=3.
module tb_vga_pattern_gen;

`ifdef AUTO_CYCLE_EN
   localparam int unsigned TB_AUTO_FRAMES = 3;
`else
   localparam int unsigned TB_AUTO_FRAMES = 120;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] red, green, blue;
   logic       h_sync_out, v_sync_out, display_en_out;

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   vga_pattern_gen_if bus ();

   always #5 clk = ~clk;

   vga_pattern_gen #(
      .H_DISPLAY   (1280),
      .V_DISPLAY   (960),
      .COLOR_W     (4),
      .CHECK_SHIFT (5),
      .GRAD_SHIFT  (6),
      .BAR_W       (32),
      .SCROLL_STEP (4),
      .AUTO_FRAMES (TB_AUTO_FRAMES)
   ) dut (
      .clk_in         (clk),
      .reset          (reset),
      .h_count        (bus.h_count),
      .v_count        (bus.v_count),
      .display_en     (bus.display_en),
      .h_sync         (bus.h_sync),
      .v_sync         (bus.v_sync),
      .mode_next      (bus.mode_next),
      .red            (red),
      .green          (green),
      .blue           (blue),
      .h_sync_out     (h_sync_out),
      .v_sync_out     (v_sync_out),
      .display_en_out (display_en_out),
      .mode           (bus.mode)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Apply one input vector and let exactly one rising edge pass
   task automatic drive(input logic [11:0] h, input logic [11:0] v, input logic de,
                        input logic hs, input logic vs, input logic mn);
      bus.h_count    = h;
      bus.v_count    = v;
      bus.display_en = de;
      bus.h_sync     = hs;
      bus.v_sync     = vs;
      bus.mode_next  = mn;
      @(negedge clk);
   endtask

   task automatic idle();
      drive(12'd1300, 12'd0, 1'b0, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic pix(input string tag, input logic [11:0] h, input logic [11:0] v,
                      input logic de, input logic [11:0] exp_rgb);
      drive(h, v, de, 1'b1, 1'b1, 1'b0);
      idle();
      check_eq(tag, {20'd0, red, green, blue}, {20'd0, exp_rgb});
   endtask

   task automatic frame_end(input logic mn);
      drive(12'd0, 12'd960, 1'b0, 1'b1, 1'b1, mn);
   endtask

   task automatic request_advance();
      drive(12'd5, 12'd100, 1'b1, 1'b1, 1'b1, 1'b1);
      idle();
      frame_end(1'b0);
   endtask

   task automatic pulse_check(input string tag, input int unsigned sel);
      logic hs, vs, de, exp_idle, got;
      hs = (sel == 0) ? 1'b0 : 1'b1;
      vs = (sel == 1) ? 1'b0 : 1'b1;
      de = (sel == 2);
      exp_idle = (sel == 2) ? 1'b0 : 1'b1;
      drive(12'd1300, 12'd0, de, hs, vs, 1'b0);
      for (int unsigned n = 1; n <= 3; n++) begin
         got = (sel == 0) ? h_sync_out : (sel == 1) ? v_sync_out : display_en_out;
         check_eq($sformatf("%s_t%0d", tag, n), {31'd0, got},
                  {31'd0, (n == 2) ? ~exp_idle : exp_idle});
         idle();
      end
   endtask

   initial begin
      reset = 1'b1;
      bus.h_count = 12'd1300; bus.v_count = 12'd0; bus.display_en = 1'b0;
      bus.h_sync = 1'b1; bus.v_sync = 1'b1; bus.mode_next = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_eq("rst_rgb",  {20'd0, red, green, blue}, 32'd0);
      check_eq("rst_hs",   {31'd0, h_sync_out}, 32'd1);
      check_eq("rst_vs",   {31'd0, v_sync_out}, 32'd1);
      check_eq("rst_de",   {31'd0, display_en_out}, 32'd0);
      check_eq("rst_mode", {30'd0, bus.mode}, 32'd0);
      reset = 1'b0;
      idle();

`ifdef AUTO_CYCLE_EN
      begin
         logic [1:0] exp_mode [12] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2,
                                       2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
         for (int i = 0; i < 12; i++) begin
            if (i == 8) begin
               drive(12'd5, 12'd100, 1'b1, 1'b1, 1'b1, 1'b1);
               idle();
            end
            frame_end(1'b0);
            check_eq($sformatf("auto_fe%0d", i + 1), {30'd0, bus.mode}, {30'd0, exp_mode[i]});
            idle();
         end
      end
`else
      // Colour bars, 160 px each
      pix("bar_white0",   12'd0,    12'd0, 1'b1, 12'hFFF);
      pix("bar_white159", 12'd159,  12'd0, 1'b1, 12'hFFF);
      pix("bar_yellow",   12'd160,  12'd0, 1'b1, 12'hFF0);
      pix("bar_cyan",     12'd320,  12'd0, 1'b1, 12'h0FF);
      pix("bar_magenta",  12'd640,  12'd0, 1'b1, 12'hF0F);
      pix("bar_red",      12'd959,  12'd0, 1'b1, 12'hF00);
      pix("bar_blue",     12'd960,  12'd0, 1'b1, 12'h00F);
      pix("bar_black",    12'd1279, 12'd0, 1'b1, 12'h000);
      pix("blank_1300",   12'd1300, 12'd0, 1'b0, 12'h000);
      pix("blank_white",  12'd0,    12'd0, 1'b0, 12'h000);

      pulse_check("hs_lat", 0);
      pulse_check("vs_lat", 1);
      pulse_check("de_lat", 2);

      // Two requests in one frame give one advance, only at frame-end
      drive(12'd10, 12'd100, 1'b1, 1'b1, 1'b1, 1'b1);
      idle();
      check_eq("req1_hold", {30'd0, bus.mode}, 32'd0);
      drive(12'd10, 12'd500, 1'b1, 1'b1, 1'b1, 1'b1);
      drive(12'd0, 12'd959, 1'b1, 1'b1, 1'b1, 1'b0);
      check_eq("req2_hold", {30'd0, bus.mode}, 32'd0);
      frame_end(1'b0);                                          // fe 1
      check_eq("fe_adv1", {30'd0, bus.mode}, 32'd1);
      frame_end(1'b0);                                          // fe 2
      frame_end(1'b0);                                          // fe 3
      check_eq("fe_noreq", {30'd0, bus.mode}, 32'd1);
      frame_end(1'b1);                                          // fe 4
      check_eq("fe_samecyc", {30'd0, bus.mode}, 32'd2);
      idle();

      pix("grad_321", 12'd192,  12'd128, 1'b1, 12'h321);
      pix("grad_3ED", 12'd1279, 12'd959, 1'b1, 12'h3ED);

      request_advance();                                        // fe 5
      check_eq("to_scroll", {30'd0, bus.mode}, 32'd3);
      idle();
      pix("scr20_19", 12'd19, 12'd0, 1'b1, 12'h000);
      pix("scr20_20", 12'd20, 12'd0, 1'b1, 12'hFFF);
      pix("scr20_51", 12'd51, 12'd0, 1'b1, 12'hFFF);
      pix("scr20_52", 12'd52, 12'd0, 1'b1, 12'h000);

      for (int i = 0; i < 314; i++) frame_end(1'b0);            // fe 319: scroll 1276
      idle();
      pix("scr1276_1275", 12'd1275, 12'd0, 1'b1, 12'h000);
      pix("scr1276_1276", 12'd1276, 12'd0, 1'b1, 12'hFFF);
      pix("scr1276_1279", 12'd1279, 12'd0, 1'b1, 12'hFFF);
      pix("scr1276_0",    12'd0,    12'd0, 1'b1, 12'h000);
      frame_end(1'b0);                                          // fe 320: scroll 0
      idle();
      pix("scr0_0",  12'd0,  12'd0, 1'b1, 12'hFFF);
      pix("scr0_31", 12'd31, 12'd0, 1'b1, 12'hFFF);
      pix("scr0_32", 12'd32, 12'd0, 1'b1, 12'h000);
      check_eq("scroll_mode_kept", {30'd0, bus.mode}, 32'd3);

      request_advance();
      check_eq("wrap_mode0", {30'd0, bus.mode}, 32'd0);
      idle();
      pix("bars_again", 12'd0, 12'd0, 1'b1, 12'hFFF);

      request_advance();
      check_eq("to_check", {30'd0, bus.mode}, 32'd1);
      idle();
      pix("chk_0_0",   12'd0,  12'd0,  1'b1, 12'hFFF);
      pix("chk_32_0",  12'd32, 12'd0,  1'b1, 12'h000);
      pix("chk_32_32", 12'd32, 12'd32, 1'b1, 12'hFFF);
      pix("chk_0_32",  12'd0,  12'd32, 1'b1, 12'h000);
      pix("chk_blank", 12'd0,  12'd0,  1'b0, 12'h000);

      // Mid-line reset in GRAD with a pending request
      request_advance();
      check_eq("to_grad", {30'd0, bus.mode}, 32'd2);
      drive(12'd5, 12'd200, 1'b1, 1'b1, 1'b1, 1'b1);
      drive(12'd1279, 12'd959, 1'b1, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      drive(12'd1279, 12'd959, 1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("mrst_mode", {30'd0, bus.mode}, 32'd0);
      check_eq("mrst_rgb",  {20'd0, red, green, blue}, 32'd0);
      check_eq("mrst_hs",   {31'd0, h_sync_out}, 32'd1);
      check_eq("mrst_vs",   {31'd0, v_sync_out}, 32'd1);
      reset = 1'b0;
      idle();
      check_eq("mrst_flush", {20'd0, red, green, blue}, 32'd0);
      frame_end(1'b0);
      check_eq("mrst_pending", {30'd0, bus.mode}, 32'd0);
      idle();
      pix("mrst_scroll0", 12'd0, 12'd0, 1'b1, 12'hFFF);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
Downstream consumer of the 640x480-family sync generator. Takes registered h/v pixel counts, display enable and sync strobes, and produces per-pixel RGB test patterns (colour bars, checkerboard, gradient, scrolling bar). Pattern mode is switched at frame boundaries by an FSM. Syncs and enable are re-timed so all outputs arrive aligned at the VGA pins.

Parameters:
H_DISPLAY, 1280, visible pixels per line; must be a multiple of 8.
V_DISPLAY, 960, visible lines per frame.
COLOR_W, 4, bits per colour channel.
CHECK_SHIFT, 5, checker cell size is 2^CHECK_SHIFT pixels.
GRAD_SHIFT, 6, LSB index of the count slice used for gradient.
BAR_W, 32, scrolling bar width in pixels.
SCROLL_STEP, 4, pixels the bar advances per frame.
AUTO_FRAMES, 120, frames per auto-advance; used only with AUTO_CYCLE_EN.

Ports:
clk_in  in  1  pixel clock
reset  in  1  synchronous, active-high reset
h_count  in  12  horizontal pixel position
v_count  in  12  vertical line position
display_en  in  1  visible-area flag, aligned with counts
h_sync  in  1  active-low hsync, aligned with counts
v_sync  in  1  active-low vsync, aligned with counts
mode_next  in  1  single-cycle request to advance pattern
red  out  COLOR_W  red channel
green  out  COLOR_W  green channel
blue  out  COLOR_W  blue channel
h_sync_out  out  1  hsync delayed to match RGB
v_sync_out  out  1  vsync delayed to match RGB
display_en_out  out  1  enable delayed to match RGB
mode  out  2  current pattern mode

Behaviour:
- One clock (clk_in); reset synchronous, active-high. Reset values: red/green/blue=0, h_sync_out=1, v_sync_out=1, display_en_out=0, mode=BARS, scroll_x=0, pending=0, frame counter=0.
- Latency: exactly 2 cycles from any input sample to the corresponding outputs. Stage 1 registers the inputs and the pattern intermediates. Stage 2 registers the final RGB and the delayed syncs/enable.
- RGB is forced to 0 whenever the delayed enable is 0 (blanking).
- Modes: BARS=0, CHECK=1, GRAD=2, SCROLL=3. Advance order is BARS->CHECK->GRAD->SCROLL->BARS.
- BARS: 8 equal bars of width H_DISPLAY/8, in order white, yellow, cyan, green, magenta, red, blue, black. Bar index comes from constant comparators, not a divider. "Full" means all-ones, "0" means all-zeros.
- CHECK: pixel is white if h_count[CHECK_SHIFT]^v_count[CHECK_SHIFT]=0, else black.
- GRAD: red=h_count[GRAD_SHIFT +: COLOR_W], green=v_count[GRAD_SHIFT +: COLOR_W], blue=red^green. Values truncate and wrap.
- SCROLL: white when scroll_x <= h_count < scroll_x+BAR_W, else black. The bar clips at the right edge and does not wrap.
- Frame-end event: asserted on the input cycle where v_count==V_DISPLAY and h_count==0. It occurs once per frame.
- mode_next sets pending. At frame-end, if pending (or mode_next is high that same cycle): mode advances once and pending clears.
- Multiple requests within one frame collapse to a single advance. A mode change never occurs mid-frame.
- scroll_x updates at every frame-end regardless of mode: if scroll_x+SCROLL_STEP >= H_DISPLAY, next value is scroll_x+SCROLL_STEP-H_DISPLAY; otherwise scroll_x+SCROLL_STEP.
- Reset asserted mid-frame takes effect on the next edge. The pipeline contents are discarded, not flushed.

Optional Feature:
AUTO_CYCLE_EN
- Defined: a frame counter counts frame-end events. When it reaches AUTO_FRAMES-1 it wraps to 0 and the mode advances. An auto advance and a pending request on the same frame-end give one advance, not two.
- Undefined: counter logic is absent and the mode changes only via mode_next. AUTO_FRAMES is ignored.

Decomposition:
- Package vga_pattern_pkg holds: mode encodings; the 8 bar colours as 3-bit RGB on/off constants, expanded to COLOR_W; pipeline latency constant (2).
- Sub-module vga_pattern_mode_ctrl holds the frame-end detect, pending flag, mode FSM, scroll_x register and optional auto counter.
- The top holds the two-stage datapath.

Test Plan:
All scenarios use default parameters.
1. Release reset, mode BARS. Drive (h=0,v=0,de=1) -> RGB=F,F,F two cycles later. h=160 -> F,F,0. h=1279 -> 0,0,0.
2. de=0, h=1300 -> RGB=0. Pulse h_sync low at cycle t -> h_sync_out low at exactly t+2. Same for v_sync and display_en.
3. Pulse mode_next at v=100, then again at v=500 -> mode stays 0 until the frame-end cycle (v=960,h=0), then becomes 1 (single advance). Starting from mode 3, one request -> mode 0.
4. Mode CHECK: (h=0,v=0) -> white; (32,0) -> black; (32,32) -> white; de=0 -> black.
5. Mode SCROLL: after 5 frame-ends scroll_x=20, so h=20..51 white and h=52 black. After 320 frame-ends scroll_x wraps to 0. Set scroll_x=1276 -> next frame-end gives 0.
6. Assert reset mid-line in mode GRAD with pending set -> next cycle: mode 0, pending 0, RGB 0, syncs 1. With AUTO_CYCLE_EN and AUTO_FRAMES=3 -> mode advances on every 3rd frame-end.
